csr_machine_file: RTL
=====================

// Module: csr_machine_file
// PURPOSE
//  Machine-mode CSR storage and update engine. Holds mstatus, mtvec, mscratch, mepc, mcause and mtval.
//  Executes CSRRW/CSRRS/CSRRC requests addressed by the 3-bit CSR index from the CSR address decoder.
//  Performs trap entry and mret. Drives the PC redirect to the fetch stage. Sits after that decoder, beside the EX stage.
// PARAMETERS
//  XLEN        32            data width
//  MTVEC_RST   32'h8000_0000 mtvec reset value
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  req_valid    in   1     CSR op request
//  req_ready    out  1     request accepted when req_valid&&req_ready
//  req_idx      in   3     CSR index: 000 mstatus, 001 mtvec, 010 mscratch, 011 mepc, 100 mcause, 101 mtval, 110 invalid
//  req_op       in   2     01 RW, 10 RS, 11 RC; 00 treated as invalid
//  req_wdata    in   XLEN  rs1 value or zimm (zero-extended upstream)
//  req_wen      in   1     0 = read-only (RS/RC with rs1==x0), no write performed
//  resp_valid   out  1     response held until resp_ready
//  resp_ready   in   1     consumer accepts response
//  resp_rdata   out  XLEN  old CSR value (value before this op's write)
//  resp_illegal out  1     op targeted an invalid index or op code
//  trap_valid   in   1     one-cycle trap request from commit
//  trap_cause   in   XLEN  mcause value; bit XLEN-1 = interrupt
//  trap_epc     in   XLEN  faulting PC
//  trap_tval    in   XLEN  trap value
//  mret_valid   in   1     one-cycle mret from commit
//  redir_valid  out  1     one-cycle PC redirect
//  redir_pc     out  XLEN  redirect target
//  mie_o        out  1     mstatus.MIE, for interrupt gating
// BEHAVIOUR
//  Reset values: mstatus=0 (MPP reads 2'b11); mtvec=MTVEC_RST; mscratch, mepc, mcause, mtval = 0.
//  Reset outputs: resp_valid=0, redir_valid=0, FSM in IDLE. Reset mid-response drops the response.
//  FSM IDLE: req_ready = !trap_valid && !mret_valid.
//  IDLE, on accept: capture old value into resp_rdata, apply the write, go to RESP. Write is visible on the next cycle.
//  RESP: resp_valid=1, req_ready=0. Return to IDLE when resp_ready (no back-to-back accept in the same cycle).
//  Write value: RW=wdata; RS=old|wdata; RC=old&~wdata. No write if req_wen=0 or illegal.
//  Illegal (idx 110/111 or op 00): no state change, resp_rdata=0, resp_illegal=1.
//  WARL masks:
//   - mstatus: only MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits read 0.
//   - mtvec: bit1 reads 0.
//   - mepc: bits[1:0] read 0.
//   - mcause, mtval, mscratch: fully writable.
//  Priority per cycle: trap > mret > CSR write. Trap and mret are never blocked by the FSM.
//  Trap entry: mepc<=trap_epc&~3; mcause<=trap_cause; mtval<=trap_tval; MPIE<=MIE; MIE<=0.
//   - redir_valid=1 next cycle.
//   - redir_pc = mtvec[1:0]==01 && cause[XLEN-1] ? {base,2'b00}+4*cause[XLEN-2:0] : {base,2'b00}.
//  mret: MIE<=MPIE; MPIE<=1; redir_valid=1 next cycle; redir_pc = mepc.
//  trap_valid && mret_valid together: trap taken, mret ignored.
//  Trap during RESP: response already captured is delivered unchanged; trap updates state.
//  Redirect uses state before that cycle's update (mtvec/mepc as registered). Latency is 1 cycle from trap/mret to redir_valid.
//  mie_o is the registered MIE.
// STRUCTURE
//  Shared package mill_csr_pkg:
//   - csr_idx_e enum for the 7 index codes;
//   - csr_op_e enum;
//   - MSTATUS_MIE, MSTATUS_MPIE, MSTATUS_MPP bit positions;
//   - MSTATUS_WMASK.
//  Sub-module csr_wdata_alu: combinational old/wdata/op/mask -> new value, reused per register.
// TESTING
//  1. After reset: read mtvec (RS, wen=0) -> rdata=32'h8000_0000, illegal=0; mstatus read -> 32'h0000_1800.
//  2. RW mscratch 32'hDEAD_BEEF, then RC with 32'h0000_FFFF -> second rdata=32'hDEAD_BEEF, final read 32'hDEAD_0000.
//  3. RW mstatus 32'hFFFF_FFFF -> readback 32'h0000_1888. mepc RW 32'h1003 -> readback 32'h1000.
//  4. MIE=1, mtvec=32'h100, trap cause 2, epc 32'h2004:
//     -> redir_pc=32'h100, mepc=32'h2004, MIE=0, MPIE=1.
//     mret -> redir_pc=32'h2004, MIE=1.
//  5. mtvec=32'h101, trap cause 32'h8000_0007 -> redir_pc=32'h11C.
//     Trap and mret in the same cycle -> trap only.
//  6. req with idx 110 -> resp_illegal=1, no state change.
//     Hold resp_ready=0 for 3 cycles -> resp stable, req_ready=0.
//     Assert rst in RESP -> resp_valid=0 next cycle.

Source files
------------

// File: rtl/mill_csr_pkg.sv
// Shared types and constants for the machine-mode CSR file.
package mill_csr_pkg;

  // CSR index codes produced by the upstream address decoder
  typedef enum logic [2:0] {
    CSR_MSTATUS  = 3'b000,
    CSR_MTVEC    = 3'b001,
    CSR_MSCRATCH = 3'b010,
    CSR_MEPC     = 3'b011,
    CSR_MCAUSE   = 3'b100,
    CSR_MTVAL    = 3'b101,
    CSR_INVALID  = 3'b110
  } csr_idx_e;

  // CSR instruction flavours; OP_NONE is rejected as illegal
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  // Request/response handshake state
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } resp_state_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Only MIE and MPIE are backed by storage
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  // MPP is hardwired to machine mode
  localparam logic [31:0] MSTATUS_RO1   = 32'h0000_1800;
  localparam logic [31:0] MTVEC_MASK    = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK     = 32'hFFFF_FFFC;

  // True when the index/op pair cannot be executed
  function automatic logic csr_is_illegal(input logic [2:0] idx, input logic [1:0] op);
    logic bad_s;
    bad_s = (idx == 3'b110) || (idx == 3'b111) || (op == 2'b00);
    return bad_s;
  endfunction

endpackage

// File: rtl/csr_wdata_alu.sv
// Computes the post-write value of a CSR from its old value, the operand and
// the op, then restricts the result to the register's legal bits.
module csr_wdata_alu
  import mill_csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] mask_i,
  output logic [XLEN-1:0] new_o
);

  logic [XLEN-1:0] raw_s;

  // Select the read-modify-write result and apply the WARL mask
  always_comb begin
    raw_s = old_i;
    case (csr_op_e'(op_i))
      OP_RW:   raw_s = wdata_i;
      OP_RS:   raw_s = old_i | wdata_i;
      OP_RC:   raw_s = old_i & ~wdata_i;
      default: raw_s = old_i;
    endcase
    new_o = raw_s & mask_i;
  end

endmodule

// File: rtl/csr_machine_file.sv
// Machine-mode CSR storage: CSRRW/RS/RC execution with a held response,
// trap entry, mret and the resulting fetch redirect.
module csr_machine_file
  import mill_csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_idx,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_wen,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic            mie_o
);

  resp_state_e     state_q, state_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_illegal_q, resp_illegal_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  logic [XLEN-1:0] old_s;
  logic [XLEN-1:0] mask_s;
  logic [XLEN-1:0] new_s;
  logic            illegal_s;
  logic            accept_s;
  logic [XLEN-1:0] trap_base_s;
  logic [XLEN-1:0] trap_off_s;

  // Current architectural value and legal-bit mask of the addressed CSR
  always_comb begin
    old_s  = '0;
    mask_s = '0;
    case (csr_idx_e'(req_idx))
      CSR_MSTATUS: begin
        old_s  = mstatus_q | XLEN'(MSTATUS_RO1);
        mask_s = XLEN'(MSTATUS_WMASK);
      end
      CSR_MTVEC: begin
        old_s  = mtvec_q;
        mask_s = {{(XLEN-32){1'b1}}, MTVEC_MASK};
      end
      CSR_MSCRATCH: begin
        old_s  = mscratch_q;
        mask_s = '1;
      end
      CSR_MEPC: begin
        old_s  = mepc_q;
        mask_s = {{(XLEN-32){1'b1}}, MEPC_MASK};
      end
      CSR_MCAUSE: begin
        old_s  = mcause_q;
        mask_s = '1;
      end
      CSR_MTVAL: begin
        old_s  = mtval_q;
        mask_s = '1;
      end
      default: begin
        old_s  = '0;
        mask_s = '0;
      end
    endcase
  end

  csr_wdata_alu #(.XLEN(XLEN)) u_alu (
    .old_i   (old_s),
    .wdata_i (req_wdata),
    .op_i    (req_op),
    .mask_i  (mask_s),
    .new_o   (new_s)
  );

  assign illegal_s   = csr_is_illegal(req_idx, req_op);
  assign req_ready   = (state_q == ST_IDLE) && !trap_valid && !mret_valid;
  assign accept_s    = req_valid && req_ready;
  assign trap_base_s = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_off_s  = {trap_cause[XLEN-3:0], 2'b00};

  // Next-state: handshake, CSR write, then trap/mret which take priority
  always_comb begin
    state_d        = state_q;
    mstatus_d      = mstatus_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;
    redir_valid_d  = 1'b0;
    redir_pc_d     = redir_pc_q;

    if (state_q == ST_IDLE) begin
      if (accept_s) begin
        state_d        = ST_RESP;
        resp_rdata_d   = illegal_s ? '0 : old_s;
        resp_illegal_d = illegal_s;
        if (!illegal_s && req_wen) begin
          case (csr_idx_e'(req_idx))
            CSR_MSTATUS:  mstatus_d  = new_s;
            CSR_MTVEC:    mtvec_d    = new_s;
            CSR_MSCRATCH: mscratch_d = new_s;
            CSR_MEPC:     mepc_d     = new_s;
            CSR_MCAUSE:   mcause_d   = new_s;
            CSR_MTVAL:    mtval_d    = new_s;
            default:      mtval_d    = mtval_q;
          endcase
        end else begin
          mtval_d = mtval_q;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      if (resp_ready) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_RESP;
      end
    end

    if (trap_valid) begin
      mepc_d                  = trap_epc & {{(XLEN-32){1'b1}}, MEPC_MASK};
      mcause_d                = trap_cause;
      mtval_d                 = trap_tval;
      mstatus_d               = '0;
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      redir_valid_d           = 1'b1;
      if ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1]) begin
        redir_pc_d = trap_base_s + trap_off_s;
      end else begin
        redir_pc_d = trap_base_s;
      end
    end else if (mret_valid) begin
      mstatus_d               = '0;
      mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
      redir_valid_d           = 1'b1;
      redir_pc_d              = mepc_q;
    end else begin
      redir_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mstatus_q      <= '0;
      mtvec_q        <= MTVEC_RST & {{(XLEN-32){1'b1}}, MTVEC_MASK};
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      resp_rdata_q   <= '0;
      resp_illegal_q <= 1'b0;
      redir_valid_q  <= 1'b0;
      redir_pc_q     <= '0;
    end else begin
      state_q        <= state_d;
      mstatus_q      <= mstatus_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
      redir_valid_q  <= redir_valid_d;
      redir_pc_q     <= redir_pc_d;
    end
  end

  assign resp_valid   = (state_q == ST_RESP);
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;
  assign redir_valid  = redir_valid_q;
  assign redir_pc     = redir_pc_q;
  assign mie_o        = mstatus_q[MSTATUS_MIE];

endmodule
